// File: rtl/apb_pkg.sv
// Shared types for the APB master: FSM state encoding, command/response
// records and the default bus widths.
package apb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   typedef struct packed {
      logic                  write;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] rdata;
      logic                  err;
   } rsp_t;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB master: a valid/ready command in, one APB transfer, a valid/ready response out.
// Define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES wait states.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
`ifdef APB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   state_t state;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] to_cnt;
`endif

   // PADDR/PWRITE/PWDATA are loaded only on acceptance, so they stay stable
   // through the transfer and keep their last value while idle.
   always_ff @(posedge clk) begin
      // NOTE: every register here uses <= so all of them update from the same pre-edge values.
      if (rst) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
`ifdef APB_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  PSEL      <= 1'b1;
                  PWRITE    <= cmd_write;
                  PADDR     <= cmd_addr;
                  PWDATA    <= cmd_write ? cmd_wdata : '0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
               to_cnt  <= '0;
`endif
            end
            ACCESS: begin
               // PREADY wins over a timeout landing on the same cycle.
               if (PREADY) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_err   <= PSLVERR;
                  state     <= RESP;
               end
`ifdef APB_TIMEOUT_EN
               else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  to_cnt    <= to_cnt + 1'b1;
                  state     <= RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
